// File: rtl/motor_pkg.sv
// Shared definitions for the motor input conditioning blocks:
// button FSM state encodings and a width helper for counters.
package motor_pkg;

   // Button FSM state encoding (2 bits)
   typedef logic [1:0] btn_state_t;

   localparam btn_state_t BTN_IDLE    = 2'd0;
   localparam btn_state_t BTN_PRESSED = 2'd1;
   localparam btn_state_t BTN_HOLDOFF = 2'd2;

   // Number of bits needed to hold 0..value-1, never less than 1.
   function automatic int clog2_min1(input int value);
      int width;
      width = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            width = i + 1;
         end
      end
      return width;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One conditioning channel: multi-flop synchronizer for an asynchronous
// input followed by a consecutive-cycle debounce filter. The output is
// the registered stable value.
module debounce_chan #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din_raw,
   output logic dout
);
   import motor_pkg::*;

   localparam int               CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CNT_W-1:0]       cnt_q;
   logic                   stable_q;

   assign synced = sync_q[SYNC_STAGES-1];
   assign dout   = stable_q;

   // Synchronizer chain: raw input enters at bit 0, leaves at the top bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
      end
   end

   // Debounce: flip the stable value only after DEBOUNCE_CYCLES consecutive
   // disagreeing samples; any agreeing sample restarts the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else if (synced == stable_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_q <= synced;
         cnt_q    <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/motor_input_cond.sv
// Input conditioner ahead of the motor control FSM. Debounces the push
// button and both limit switches, converts a button press into a single
// activate pulse with a re-trigger hold-off after release, and flags the
// illegal both-limits-active condition.
module motor_input_cond #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLDOFF_CYCLES  = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   input  logic up_limit_raw,
   input  logic dn_limit_raw,
   output logic activate,
   output logic up_limit,
   output logic dn_limit,
   output logic limit_fault
);
   import motor_pkg::*;

   localparam int                HOLD_W    = clog2_min1(HOLDOFF_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

   logic              btn_db;
   logic              btn_prev;
   btn_state_t        state_q;
   btn_state_t        state_d;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;
   logic              activate_d;

   debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_raw (btn_raw),
      .dout    (btn_db)
   );

   debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_up_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_raw (up_limit_raw),
      .dout    (up_limit)
   );

   debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_dn_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_raw (dn_limit_raw),
      .dout    (dn_limit)
   );

   // Delayed copy of the debounced button for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_prev <= 1'b0;
      end else begin
         btn_prev <= btn_db;
      end
   end

   // Fault follows both debounced limits; it drops as soon as either falls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         limit_fault <= 1'b0;
      end else begin
         limit_fault <= up_limit & dn_limit;
      end
   end

   // Button FSM next-state, hold-off counter and pulse decision
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      activate_d = 1'b0;
      case (state_q)
         BTN_IDLE: begin
            if (btn_db && !btn_prev) begin
               state_d = BTN_PRESSED;
               // A press seen while the limits are in fault is consumed silently
               activate_d = !limit_fault;
            end
         end
         BTN_PRESSED: begin
            if (!btn_db) begin
               hold_d  = HOLD_LOAD;
               state_d = BTN_HOLDOFF;
            end
         end
         BTN_HOLDOFF: begin
            if (hold_q == '0) begin
               state_d = BTN_IDLE;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         default: begin
            state_d = BTN_IDLE;
         end
      endcase
   end

   // Button FSM state, hold-off counter and registered activate pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BTN_IDLE;
         hold_q   <= '0;
         activate <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         activate <= activate_d;
      end
   end

endmodule

// File: tb/tb_motor_input_cond.sv
// Bench for motor_input_cond with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// HOLDOFF_CYCLES=8. Expected activate pulse cycles are queued when a press
// is driven and consumed as pulses appear.
module tb_motor_input_cond;

   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int HOLDOFF_CYCLES  = 8;
   // Cycles from driving a press until activate is seen high
   localparam int PULSE_LAT = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
   // Edge (relative to driving a level) at which the debounced value flips
   localparam int DB_LAT = SYNC_STAGES + DEBOUNCE_CYCLES;

   logic clk          = 1'b0;
   logic rst_n        = 1'b1;
   logic btn_raw      = 1'b0;
   logic up_limit_raw = 1'b0;
   logic dn_limit_raw = 1'b0;
   logic activate;
   logic up_limit;
   logic dn_limit;
   logic limit_fault;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   exp_q[$];
   logic act_prev = 1'b0;

   motor_input_cond #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLDOFF_CYCLES  (HOLDOFF_CYCLES)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_raw      (btn_raw),
      .up_limit_raw (up_limit_raw),
      .dn_limit_raw (dn_limit_raw),
      .activate     (activate),
      .up_limit     (up_limit),
      .dn_limit     (dn_limit),
      .limit_fault  (limit_fault)
   );

   always #5 clk = ~clk;

   // Advance one clock, sample 1ns after the edge and consume scoreboard entries
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0 && cyc > exp_q[0]) begin
         n_checks++;
         n_errors++;
         $display("FAIL activate_missing: no pulse seen, required pulse at cycle %0d (now %0d)", exp_q[0], cyc);
         void'(exp_q.pop_front());
      end
      if (activate === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL activate_unexpected: pulse at cycle %0d, required none", cyc);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (cyc != e) begin
               n_errors++;
               $display("FAIL activate_timing: pulse at cycle %0d, required cycle %0d", cyc, e);
            end
         end
      end
      n_checks++;
      if (activate === 1'b1 && act_prev === 1'b1) begin
         n_errors++;
         $display("FAIL activate_double: activate high at cycles %0d and %0d", cyc - 1, cyc);
      end
      act_prev = activate;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({activate, up_limit, dn_limit, limit_fault} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_async: outputs %b, required 0000", {activate, up_limit, dn_limit, limit_fault});
      end
      repeat (3) tick();
      n_checks++;
      if ({activate, up_limit, dn_limit, limit_fault, dut.btn_db} !== 5'b00000) begin
         n_errors++;
         $display("FAIL reset_hold: outputs %b, required 00000", {activate, up_limit, dn_limit, limit_fault, dut.btn_db});
      end
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_clean_press();
      logic exp_db;
      btn_raw = 1'b1;
      exp_q.push_back(cyc + PULSE_LAT);
      for (int i = 1; i <= 20; i++) begin
         tick();
         exp_db = (i >= DB_LAT);
         n_checks++;
         if (dut.btn_db !== exp_db) begin
            n_errors++;
            $display("FAIL clean_press_db: edge %0d btn_db=%b, required %b", i, dut.btn_db, exp_db);
         end
      end
      btn_raw = 1'b0;
      repeat (20) tick();
   endtask

   task automatic test_glitch();
      for (int w = 1; w <= 3; w++) begin
         btn_raw = 1'b1;
         for (int i = 0; i < w + 5; i++) begin
            if (i == w) btn_raw = 1'b0;
            tick();
            n_checks++;
            if (dut.btn_db !== 1'b0 || activate !== 1'b0) begin
               n_errors++;
               $display("FAIL glitch_%0d: btn_db=%b activate=%b, required 0 0", w, dut.btn_db, activate);
            end
         end
      end
      repeat (5) tick();
   endtask

   task automatic test_holdoff();
      logic exp_db;
      // Re-press early enough that its debounced rise falls inside hold-off
      btn_raw = 1'b1;
      exp_q.push_back(cyc + PULSE_LAT);
      repeat (10) tick();
      btn_raw = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_db = (k < DB_LAT);
         n_checks++;
         if (dut.btn_db !== exp_db) begin
            n_errors++;
            $display("FAIL holdoff_release_db: edge %0d btn_db=%b, required %b", k, dut.btn_db, exp_db);
         end
      end
      btn_raw = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         tick();
         exp_db = (j >= DB_LAT);
         n_checks++;
         if (dut.btn_db !== exp_db) begin
            n_errors++;
            $display("FAIL holdoff_repress_db: edge %0d btn_db=%b, required %b", j, dut.btn_db, exp_db);
         end
      end
      btn_raw = 1'b0;
      repeat (20) tick();
      // Re-press well after hold-off expires gives exactly one pulse
      btn_raw = 1'b1;
      exp_q.push_back(cyc + PULSE_LAT);
      repeat (10) tick();
      btn_raw = 1'b0;
      repeat (16) tick();
      btn_raw = 1'b1;
      exp_q.push_back(cyc + PULSE_LAT);
      repeat (6) tick();
      btn_raw = 1'b0;
      repeat (20) tick();
   endtask

   task automatic test_limit_debounce();
      logic exp_up;
      up_limit_raw = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         exp_up = (i >= DB_LAT);
         n_checks++;
         if (up_limit !== exp_up || dn_limit !== 1'b0 || limit_fault !== 1'b0) begin
            n_errors++;
            $display("FAIL limit_rise: edge %0d up/dn/fault=%b%b%b, required %b00", i, up_limit, dn_limit, limit_fault, exp_up);
         end
      end
      up_limit_raw = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp_up = (i < DB_LAT);
         n_checks++;
         if (up_limit !== exp_up) begin
            n_errors++;
            $display("FAIL limit_fall: edge %0d up_limit=%b, required %b", i, up_limit, exp_up);
         end
      end
      up_limit_raw = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (i == 3) up_limit_raw = 1'b0;
         tick();
         n_checks++;
         if (up_limit !== 1'b0) begin
            n_errors++;
            $display("FAIL limit_glitch: edge %0d up_limit=%b, required 0", i + 1, up_limit);
         end
      end
   endtask

   task automatic test_fault();
      logic [2:0] exp_v;
      up_limit_raw = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_v = {logic'(i >= DB_LAT), logic'(i >= DB_LAT + 2), logic'(i >= DB_LAT + 3)};
         n_checks++;
         if ({up_limit, dn_limit, limit_fault} !== exp_v) begin
            n_errors++;
            $display("FAIL fault_rise: edge %0d up/dn/fault=%b, required %b", i, {up_limit, dn_limit, limit_fault}, exp_v);
         end
         if (i == 2) dn_limit_raw = 1'b1;
      end
      // Press while faulted must not pulse; scoreboard has nothing queued
      btn_raw = 1'b1;
      repeat (10) tick();
      btn_raw = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         n_checks++;
         if (limit_fault !== 1'b1) begin
            n_errors++;
            $display("FAIL fault_hold: edge %0d limit_fault=%b, required 1", i, limit_fault);
         end
      end
      dn_limit_raw = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp_v = {1'b1, logic'(i < DB_LAT), logic'(i < DB_LAT + 1)};
         n_checks++;
         if ({up_limit, dn_limit, limit_fault} !== exp_v) begin
            n_errors++;
            $display("FAIL fault_clear: edge %0d up/dn/fault=%b, required %b", i, {up_limit, dn_limit, limit_fault}, exp_v);
         end
      end
      up_limit_raw = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset_mid_press();
      up_limit_raw = 1'b1;
      repeat (8) tick();
      n_checks++;
      if (up_limit !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_pre_up: up_limit=%b, required 1", up_limit);
      end
      btn_raw = 1'b1;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({activate, up_limit, dn_limit, limit_fault, dut.btn_db} !== 5'b00000) begin
         n_errors++;
         $display("FAIL rst_mid_async: outputs %b, required 00000", {activate, up_limit, dn_limit, limit_fault, dut.btn_db});
      end
      up_limit_raw = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      exp_q.push_back(cyc + PULSE_LAT);
      repeat (12) tick();
      btn_raw = 1'b0;
      repeat (20) tick();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_holdoff();
      test_limit_debounce();
      test_fault();
      test_reset_mid_press();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL pulses_outstanding: %0d expected pulses never seen, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
